// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic array slice: default geometry,
// the lane operand type and the feeder sequencing states.
package systolic_pkg;

  localparam int DEFAULT_DIN_WIDTH = 8;
  localparam int DEFAULT_N         = 4;

  typedef logic [DEFAULT_DIN_WIDTH-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN
  } feeder_state_e;

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Upstream beat handshake plus the skewed lane bus toward the array.
//
// Handshake: a beat transfers on a rising clk edge where s_valid && s_ready.
// While s_valid is high and s_ready is low, the master holds s_a, s_b and
// s_last stable. s_last only has meaning on a transferring beat.
interface systolic_skew_feeder_if #(
  parameter int DIN_WIDTH = systolic_pkg::DEFAULT_DIN_WIDTH,
  parameter int N         = systolic_pkg::DEFAULT_N
);

  logic                          s_valid;
  logic                          s_ready;
  logic                          s_last;
  logic [N-1:0][DIN_WIDTH-1:0]   s_a;
  logic [N-1:0][DIN_WIDTH-1:0]   s_b;
  logic [N-1:0][DIN_WIDTH-1:0]   a;
  logic [N-1:0][DIN_WIDTH-1:0]   b;
  logic                          in_valid;
  logic                          busy;
  logic                          tile_done;

  // Beat source and array-side observer.
  modport master (
    output s_valid, s_last, s_a, s_b,
    input  s_ready, a, b, in_valid, busy, tile_done
  );

  // The feeder itself: consumes beats, drives the array lanes.
  modport slave (
    input  s_valid, s_last, s_a, s_b,
    output s_ready, a, b, in_valid, busy, tile_done
  );

endinterface

// File: rtl/systolic_skew_feeder_lane.sv
// Fixed-depth delay line carrying an operand plus its valid bit.
// Output data is forced to zero whenever the emerging slot is empty.
module systolic_skew_lane #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             any_valid
);

  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0]            valid_q;

  // Shift every stage each cycle; the head loads the beat or an empty slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q[0]  <= in_valid ? in_data : '0;
      valid_q[0] <= in_valid;
      for (int s = 1; s < DEPTH; s++) begin
        data_q[s]  <= data_q[s-1];
        valid_q[s] <= valid_q[s-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = valid_q[DEPTH-1] ? data_q[DEPTH-1] : '0;
  assign any_valid = |valid_q;

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skews A columns / B rows into the systolic array (lane i delayed by i
// extra cycles) and sequences each tile through feed, drain and done.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int DIN_WIDTH = DEFAULT_DIN_WIDTH,
  parameter int N         = DEFAULT_N
) (
  input  logic                    clk,
  input  logic                    rst,
  systolic_skew_feeder_if.slave   bus,
  output feeder_state_e           dbg_state
);

  localparam int CW = $clog2(N) + 1;

  feeder_state_e               state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        s_ready_c;
  logic                        accept;
  logic                        tile_done_c;
  logic [N-1:0][DIN_WIDTH-1:0] s_a_w, s_b_w, a_out, b_out;
  logic [N-1:0]                a_vld, b_vld, a_any, b_any;

  assign s_a_w     = bus.s_a;
  assign s_b_w     = bus.s_b;
  assign s_ready_c = (state_q != DRAIN);
  assign accept    = bus.s_valid && s_ready_c;

  // Lane i of each operand is a delay line of depth i+1.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    systolic_skew_lane #(.DEPTH(gi + 1), .WIDTH(DIN_WIDTH)) u_a_lane (
      .clk       (clk),
      .rst       (rst),
      .in_data   (s_a_w[gi]),
      .in_valid  (accept),
      .out_data  (a_out[gi]),
      .out_valid (a_vld[gi]),
      .any_valid (a_any[gi])
    );
    systolic_skew_lane #(.DEPTH(gi + 1), .WIDTH(DIN_WIDTH)) u_b_lane (
      .clk       (clk),
      .rst       (rst),
      .in_data   (s_b_w[gi]),
      .in_valid  (accept),
      .out_data  (b_out[gi]),
      .out_valid (b_vld[gi]),
      .any_valid (b_any[gi])
    );
  end

  // Tile sequencer state and drain counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: the last beat enters DRAIN with N-1 cycles still to go
  // before it reaches the deepest lane; done fires as it emerges there.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tile_done_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = bus.s_last ? DRAIN : FEED;
          cnt_d   = CW'(N - 1);
        end
      end
      FEED: begin
        if (accept && bus.s_last) begin
          state_d = DRAIN;
          cnt_d   = CW'(N - 1);
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          tile_done_c = a_vld[N-1];
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.s_ready   = s_ready_c;
  assign bus.a         = a_out;
  assign bus.b         = b_out;
  assign bus.in_valid  = |(a_vld | b_vld);
  assign bus.busy      = (state_q != IDLE) || (|a_any) || (|b_any);
  assign bus.tile_done = tile_done_c;
  assign dbg_state     = state_q;

endmodule
